// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and
// the bit-period helper used to size the oversampling counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int uart_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops reset to RESET_VAL so an idle line reads correctly out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry
// output register, with framing-error and overrun pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      urx_pin,
  output logic                      urx_valid,
  output logic [UART_DATA_BITS-1:0] urx_data,
  input  logic                      urx_ready,
  output logic                      urx_framing_err,
  output logic                      urx_overrun
);

  localparam int CLKS_PER_BIT = uart_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx_frontend: CLKS_PER_BIT must be at least 8");
  end

  // Handshake: a byte transfers on every cycle where urx_valid && urx_ready;
  // urx_data holds steady while urx_valid is high and not yet accepted.

  logic                      rx_s;
  uart_rx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      load, overrun_d, framing_d;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (urx_pin),
    .sync_out (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    framing_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          // Shift in from the top so the first (LSB) sample ends up in bit 0.
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // A same-cycle handshake frees the register, so the load wins.
            if (urx_valid && !urx_ready) overrun_d = 1'b1;
            else                         load      = 1'b1;
            state_d = IDLE;
          end else begin
            framing_d = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urx_valid       <= 1'b0;
      urx_data        <= '0;
      urx_framing_err <= 1'b0;
      urx_overrun     <= 1'b0;
    end else begin
      urx_framing_err <= framing_d;
      urx_overrun     <= overrun_d;
      if (load) begin
        urx_valid <= 1'b1;
        urx_data  <= shift_q;
      end else if (urx_valid && urx_ready) begin
        urx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed scenarios plus random frames, compared
// every cycle against a frame-level model of the receiver's outputs.
module tb_uart_rx_frontend;

  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int C          = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       urx_pin = 1'b1;
  logic       urx_ready = 1'b0;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_framing_err;
  logic       urx_overrun;

  uart_rx_frontend #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .urx_pin         (urx_pin),
    .urx_valid       (urx_valid),
    .urx_data        (urx_data),
    .urx_ready       (urx_ready),
    .urx_framing_err (urx_framing_err),
    .urx_overrun     (urx_overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] exp_q[$];
  int         due_q[$];
  logic       stop_q[$];

  bit ready_hold = 1'b0;
  bit rand_ready = 1'b0;
  int pulse_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance the model at the edge, compare just after it,
  // then drive urx_ready for the next edge.
  task automatic tick();
    logic full;
    logic stop;
    logic [7:0] b;
    @(posedge clk);
    cyc++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      exp_q.delete();
      due_q.delete();
      stop_q.delete();
    end else begin
      full = m_valid && !urx_ready;
      if (m_valid && urx_ready) m_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        b    = exp_q.pop_front();
        stop = stop_q.pop_front();
        if (!stop)     m_ferr = 1'b1;
        else if (full) m_ovr  = 1'b1;
        else begin
          m_valid = 1'b1;
          m_data  = b;
        end
      end
    end
    #1;
    check_eq("valid", {31'd0, urx_valid}, {31'd0, m_valid});
    check_eq("data", {24'd0, urx_data}, {24'd0, m_data});
    check_eq("framing_err", {31'd0, urx_framing_err}, {31'd0, m_ferr});
    check_eq("overrun", {31'd0, urx_overrun}, {31'd0, m_ovr});
    if (rand_ready) urx_ready = 1'($urandom_range(0, 1));
    else            urx_ready = ready_hold || (cyc + 1 == pulse_cyc);
  endtask

  task automatic hold_pin(input logic v, input int n);
    urx_pin = v;
    repeat (n) tick();
  endtask

  // Start bit is first sampled at edge cyc+1; two synchronizer edges, half a
  // bit to the start-bit middle and nine bits to the stop-bit middle, then
  // the result registers on the following edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    due_q.push_back(cyc + 1 + 2 + C / 2 + 9 * C);
    exp_q.push_back(b);
    stop_q.push_back(stop);
    hold_pin(1'b0, C);
    for (int i = 0; i < 8; i++) hold_pin(b[i], C);
    if (stop) hold_pin(1'b1, C);
    else      hold_pin(1'b0, C + extra_low);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;

    // reset state
    repeat (3) tick();
    rst_n = 1'b1;
    hold_pin(1'b1, 10);

    // single byte, consumer always ready
    ready_hold = 1'b1;
    send_frame(8'hA5, 1'b1, 0);
    hold_pin(1'b1, 10);

    // backpressure: second back-to-back frame overruns, then drain
    ready_hold = 1'b0;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    hold_pin(1'b1, 10);
    ready_hold = 1'b1;
    hold_pin(1'b1, 5);

    // framing error with a held-low break, then a good frame
    send_frame(8'h3C, 1'b0, 40);
    hold_pin(1'b1, 2 * C);
    send_frame(8'h55, 1'b1, 0);
    hold_pin(1'b1, 10);

    // glitch rejection
    hold_pin(1'b0, 4);
    hold_pin(1'b1, 20);
    send_frame(8'hF0, 1'b1, 0);
    hold_pin(1'b1, 10);

    // reset during data bit 3 of 0xFF while a byte is still held
    ready_hold = 1'b0;
    send_frame(8'h42, 1'b1, 0);
    hold_pin(1'b0, C);
    hold_pin(1'b1, 3 * C + C / 2);
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    #1;
    check_eq("rst_valid", {31'd0, urx_valid}, 32'd0);
    check_eq("rst_data", {24'd0, urx_data}, 32'd0);
    check_eq("rst_framing_err", {31'd0, urx_framing_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, urx_overrun}, 32'd0);
    urx_pin = 1'b1;
    repeat (5) tick();
    rst_n = 1'b1;
    ready_hold = 1'b1;
    hold_pin(1'b1, 10);
    send_frame(8'h81, 1'b1, 0);
    hold_pin(1'b1, 10);

    // handshake and new load in the same cycle
    ready_hold = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    pulse_cyc = cyc + 1 + 2 + C / 2 + 9 * C;
    send_frame(8'h22, 1'b1, 0);
    hold_pin(1'b1, 10);
    ready_hold = 1'b1;
    hold_pin(1'b1, 5);

    // random bytes, stop bits, gaps and consumer readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, $urandom_range(0, 20));
      if (rs) hold_pin(1'b1, $urandom_range(0, 12));
      else    hold_pin(1'b1, C + $urandom_range(0, 12));
    end
    rand_ready = 1'b0;
    ready_hold = 1'b1;
    hold_pin(1'b1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Oversampling UART receiver that converts the asynchronous `urx_pin` serial line into a stream of bytes on a valid/ready interface. It sits directly downstream of the board RX pin and directly upstream of the demo's byte-consuming logic. It also reports framing errors and overruns. Format is fixed 8N1, LSB first.

## Interface
Parameters:
- `CLOCK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
  - `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` (integer division).
  - `CLKS_PER_BIT` must be ≥ 8; enforced by an elaboration-time assertion.

Ports:
- `clk` input 1: single system clock; all logic runs in this domain.
- `rst_n` input 1: asynchronous active-low reset.
- `urx_pin` input 1: raw serial line, asynchronous to `clk`, idle high.
- `urx_valid` output 1: `urx_data` holds an unconsumed byte.
- `urx_data` output 8: received byte.
- `urx_ready` input 1: consumer accepts the byte when `urx_valid && urx_ready`.
- `urx_framing_err` output 1: one-cycle pulse when a bad stop bit is detected.
- `urx_overrun` output 1: one-cycle pulse when a completed byte is dropped because the output is still full.

## Operation
- **Input synchronizer:** `urx_pin` passes through a 2-flop synchronizer; both flops reset to 1. The FSM sees only the synchronized value, `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rx_s == 0`, clear the bit counter and enter START.
- **START:** wait `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
  - 0: enter DATA with the bit counter reloaded to `CLKS_PER_BIT`.
  - 1: treat as a glitch and return to IDLE. No output activity.
- **DATA:** sample `rx_s` every `CLKS_PER_BIT` cycles. Shift each sample into bit position 0..7 (LSB first). After the 8th sample, enter STOP.
- **STOP:** sample `rx_s` after `CLKS_PER_BIT` cycles.
  - 1, output empty: load `urx_data`, set `urx_valid`, go to IDLE.
  - 1, output full: keep the old byte, pulse `urx_overrun`, go to IDLE.
  - 0: pulse `urx_framing_err`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s == 1`, then go to IDLE. This covers a break condition.
- **Output register:** `urx_valid` clears on the handshake. If the handshake and a new STOP load land in the same cycle, the load wins: `urx_valid` stays 1 and `urx_data` takes the new byte, with no overrun pulse.
- **Reset** (async, at any time, including mid-frame): FSM → IDLE. Counters, shift register and all outputs clear. A frame in progress is abandoned silently.

## Timing
- Reset values: `urx_valid`=0, `urx_data`=8'h00, `urx_framing_err`=0, `urx_overrun`=0.
- Synchronizer latency is 2 cycles.
- Let t0 be the first cycle with `rx_s == 0` in IDLE.
  - Data bit k is sampled at t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
  - `urx_valid`, `urx_framing_err` or `urx_overrun` asserts the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit arriving immediately after the stop bit is caught. No inter-frame gap is required.
- Error pulses are exactly one cycle wide and never coincide with a new `urx_valid` load.
- `urx_data` is stable while `urx_valid` is 1 and the consumer has not accepted it.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - `UART_DATA_BITS = 8`.
  - A function computing `CLKS_PER_BIT` from `CLOCK_FREQ` and `BAUD_RATE`.
- Bit-time counter width is `$clog2(CLKS_PER_BIT)`.
- Bit index counter is 3 bits.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer with a reset-value parameter (used here with 1).

## Test plan
All scenarios use `CLOCK_FREQ`=1_600_000 and `BAUD_RATE`=100_000, so `CLKS_PER_BIT`=16.
- **Single byte:** drive frame 0xA5 with `urx_ready` held 1 → `urx_valid` high for exactly 1 cycle with `urx_data`=0xA5, at t0+153 cycles. No error pulses.
- **Backpressure/overrun:** hold `urx_ready`=0 and send 0x12 then 0x34 back-to-back → `urx_valid` stays 1 with `urx_data`=0x12, and `urx_overrun` pulses once at the end of the 2nd frame. Raise `urx_ready` → `urx_valid` drops after one handshake.
- **Framing error:** send 0x3C with stop bit 0, held low 40 extra cycles, then 0x55 → one `urx_framing_err` pulse and no valid for 0x3C, then `urx_data`=0x55 valid.
- **Glitch rejection:** 4-cycle low pulse on `urx_pin` → no output activity; the following frame 0xF0 is received correctly.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of 0xFF → all outputs 0 immediately. Release reset, send 0x81 → `urx_data`=0x81 valid, no errors.
- **Simultaneous accept and load:** `urx_valid`=1 with 0x11, and `urx_ready` pulsed in the same cycle that 0x22 completes → `urx_valid` stays 1, `urx_data`=0x22, no overrun.
